// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl
//   Direct-mapped, one-word-per-line data cache controller for the MEM stage.
//   Read hits return data in the same cycle. Read misses fill the line from
//   main memory. Every write goes through to memory and allocates the line.
//   `hit`=0 stalls the EX/MEM register until the access has completed.
//
// Ports
//   clock, reset          rising-edge clock; synchronous active-high reset
//   MemRead, MemWrite     load / store request (a store wins if both are set)
//   address, writeData    byte address (bits [1:0] ignored) and store data
//   readData, hit         load data and the no-stall indication (combinational)
//   memReq, memWe         registered request and write-enable to main memory
//   memAddr, memWData     registered word-aligned address and write data
//   memRData, memReady    memory read data and its one-cycle completion pulse
module data_cache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        hit,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MEM, WR_MEM, DONE} state_t;

  state_t state_reg, state_next;

  logic                valid_reg [LINES];
  logic [TAG_BITS-1:0] tag_mem   [LINES];
  logic [31:0]         data_mem  [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  line_hit;
  logic                  fill;
  logic [31:0]           fill_data;
  logic                  unused_bits;

  assign index       = address[INDEX_BITS+1:2];
  assign tag         = address[31:INDEX_BITS+2];
  assign unused_bits = &{1'b0, address[1:0]};
  assign line_hit    = valid_reg[index] && (tag_mem[index] == tag);

  // A line is written only on the memReady edge of an outstanding access;
  // memReady seen in IDLE or DONE never reaches the arrays.
  assign fill      = ((state_reg == RD_MEM) || (state_reg == WR_MEM)) && memReady;
  assign fill_data = (state_reg == RD_MEM) ? memRData : writeData;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Valid bits are the only cache state that must be cleared on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        valid_reg[i] <= 1'b0;
      end
    end else if (fill) begin
      valid_reg[index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && fill) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= fill_data;
    end
  end

  // Memory-side request registers. They are loaded once, when the access
  // leaves IDLE, and held unchanged until memReady arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= 32'd0;
      memWData <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (MemWrite) begin
            memReq   <= 1'b1;
            memWe    <= 1'b1;
            memAddr  <= {address[31:2], 2'b00};
            memWData <= writeData;
          end else if (MemRead && !line_hit) begin
            memReq  <= 1'b1;
            memWe   <= 1'b0;
            memAddr <= {address[31:2], 2'b00};
          end
        end
        RD_MEM, WR_MEM: begin
          if (memReady) begin
            memReq <= 1'b0;
            memWe  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    hit        = 1'b0;
    readData   = 32'd0;
    case (state_reg)
      IDLE: begin
        if (MemWrite) begin
          state_next = WR_MEM;
        end else if (MemRead) begin
          if (line_hit) begin
            hit      = 1'b1;
            readData = data_mem[index];
          end else begin
            state_next = RD_MEM;
          end
        end else begin
          // Bubbles never stall.
          hit = 1'b1;
        end
      end
      RD_MEM, WR_MEM: begin
        if (memReady) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The requester still holds its inputs here, so they tell us whether
        // this completion belongs to a load (return data) or a store (zero).
        hit        = 1'b1;
        state_next = IDLE;
        if (MemRead && !MemWrite) begin
          readData = data_mem[index];
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Testbench for data_cache_ctrl: scenario tasks drive loads/stores, play the
// role of main memory, and compare load data against a scoreboard queue.
module tb_data_cache_ctrl;

  logic        clock;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        hit;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memReady;

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] sb [$];

  data_cache_ctrl #(.INDEX_BITS(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .hit      (hit),
    .memReq   (memReq),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memWData (memWData),
    .memRData (memRData),
    .memReady (memReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One access. Called just after a rising edge with the DUT in IDLE.
  // exp_hit=1: zero-stall hit expected. Otherwise a miss/write is expected:
  // memory answers on the n-th cycle of memReq being high with `fill`.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_hit, input int n,
                        input logic [31:0] fill, input logic [31:0] exp_rd);
    logic [31:0] exp;
    logic [31:0] aligned;
    aligned   = {addr[31:2], 2'b00};
    MemRead   = rd;
    MemWrite  = wr;
    address   = addr;
    writeData = wd;
    if (rd && !wr) sb.push_back(exp_rd);
    @(negedge clock);
    if (exp_hit) begin
      vectors++;
      if (hit !== 1'b1) begin
        miscompares++;
        $display("FAIL %s hit: got %b want 1", name, hit);
      end
      if (rd && !wr) begin
        exp = sb.pop_front();
        vectors++;
        if (readData !== exp) begin
          miscompares++;
          $display("FAIL %s readData: got %h want %h", name, readData, exp);
        end
      end
      vectors++;
      if (memReq !== 1'b0) begin
        miscompares++;
        $display("FAIL %s memReq on hit: got %b want 0", name, memReq);
      end
    end else begin
      vectors++;
      if (hit !== 1'b0) begin
        miscompares++;
        $display("FAIL %s first-cycle stall: hit got %b want 0", name, hit);
      end
      @(negedge clock);
      for (int k = 1; k <= n; k++) begin
        vectors++;
        if (hit !== 1'b0 || memReq !== 1'b1 || memWe !== wr || memAddr !== aligned) begin
          miscompares++;
          $display("FAIL %s wait cycle %0d: hit=%b memReq=%b memWe=%b memAddr=%h want hit=0 memReq=1 memWe=%b memAddr=%h",
                   name, k, hit, memReq, memWe, memAddr, wr, aligned);
        end
        if (wr) begin
          vectors++;
          if (memWData !== wd) begin
            miscompares++;
            $display("FAIL %s memWData cycle %0d: got %h want %h", name, k, memWData, wd);
          end
        end
        if (k == n) begin
          memReady = 1'b1;
          memRData = fill;
          @(posedge clock);
          #1;
          memReady = 1'b0;
          memRData = 32'hxxxx_xxxx;
        end
        @(negedge clock);
      end
      vectors++;
      if (hit !== 1'b1 || memReq !== 1'b0 || memWe !== 1'b0) begin
        miscompares++;
        $display("FAIL %s done cycle: hit=%b memReq=%b memWe=%b want 1 0 0", name, hit, memReq, memWe);
      end
      if (hit === 1'b1 && rd && !wr) begin
        exp = sb.pop_front();
        vectors++;
        if (readData !== exp) begin
          miscompares++;
          $display("FAIL %s readData: got %h want %h", name, readData, exp);
        end
      end else if (hit !== 1'b1 && rd && !wr) begin
        void'(sb.pop_front());
      end else begin
        vectors++;
        if (readData !== 32'd0) begin
          miscompares++;
          $display("FAIL %s write done readData: got %h want 0", name, readData);
        end
      end
      // The DONE pulse must last exactly one cycle.
      @(negedge clock);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      #1;
      vectors++;
      if (memReq !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after done memReq: got %b want 0", name, memReq);
      end
      @(posedge clock);
      #1;
      $display("txn %s rd=%b wr=%b addr=%h wdata=%h exp_hit=%b", name, rd, wr, addr, wd, exp_hit);
      return;
    end
    @(posedge clock);
    #1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    $display("txn %s rd=%b wr=%b addr=%h wdata=%h exp_hit=%b", name, rd, wr, addr, wd, exp_hit);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (memReq !== 1'b0 || memWe !== 1'b0 || memAddr !== 32'd0 || memWData !== 32'd0) begin
      miscompares++;
      $display("FAIL reset regs: memReq=%b memWe=%b memAddr=%h memWData=%h want all 0",
               memReq, memWe, memAddr, memWData);
    end
    vectors++;
    if (hit !== 1'b1 || readData !== 32'd0) begin
      miscompares++;
      $display("FAIL reset idle: hit=%b readData=%h want 1 0", hit, readData);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    $display("txn reset");
  endtask

  task automatic test_read_miss_hit;
    access("rd_miss_40", 1, 0, 32'h40, 0, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF);
    access("rd_hit_40",  1, 0, 32'h40, 0, 1, 0, 0,            32'hDEADBEEF);
  endtask

  task automatic test_write_then_read;
    access("wr_44",     0, 1, 32'h44, 32'h12345678, 0, 2, 32'hFFFF0000, 0);
    access("rd_hit_44", 1, 0, 32'h44, 0, 1, 0, 0, 32'h12345678);
  endtask

  task automatic test_alias;
    access("rd_miss_440", 1, 0, 32'h440, 0, 0, 4, 32'h0BADF00D, 32'h0BADF00D);
    access("rd_hit_440",  1, 0, 32'h440, 0, 1, 0, 0, 32'h0BADF00D);
    access("rd_evict_40", 1, 0, 32'h40,  0, 0, 1, 32'hCAFE0040, 32'hCAFE0040);
    access("rd_hit_40b",  1, 0, 32'h40,  0, 1, 0, 0, 32'hCAFE0040);
  endtask

  task automatic test_write_allocate;
    access("wr_444",      0, 1, 32'h444, 32'h44440444, 0, 1, 0, 0);
    access("rd_hit_444",  1, 0, 32'h444, 0, 1, 0, 0, 32'h44440444);
    access("rd_miss_44",  1, 0, 32'h44,  0, 0, 2, 32'h00000044, 32'h00000044);
  endtask

  task automatic test_reset_mid_miss;
    MemRead = 1'b1;
    address = 32'h100;
    @(negedge clock);
    vectors++;
    if (hit !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst stall: hit got %b want 0", hit);
    end
    @(negedge clock);
    vectors++;
    if (memReq !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst memReq: got %b want 1", memReq);
    end
    reset   = 1'b1;
    MemRead = 1'b0;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    memReady = 1'b1;
    memRData = 32'h55555555;
    @(negedge clock);
    vectors++;
    if (memReq !== 1'b0 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst idle: memReq=%b hit=%b want 0 1", memReq, hit);
    end
    @(posedge clock);
    #1;
    memReady = 1'b0;
    $display("txn reset_mid_miss addr=00000100");
    access("rd_miss_100", 1, 0, 32'h100, 0, 0, 2, 32'h77777777, 32'h77777777);
  endtask

  task automatic test_rd_wr_priority;
    access("rdwr_80",    1, 1, 32'h80, 32'hA5A5A5A5, 0, 2, 32'h11111111, 0);
    access("rd_hit_80",  1, 0, 32'h80, 0, 1, 0, 0, 32'hA5A5A5A5);
  endtask

  task automatic test_idle;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vectors++;
      if (hit !== 1'b1 || readData !== 32'd0 || memReq !== 1'b0) begin
        miscompares++;
        $display("FAIL idle cycle %0d: hit=%b readData=%h memReq=%b want 1 0 0", i, hit, readData, memReq);
      end
      $display("txn idle cycle %0d", i);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] model [4];
    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom;
      access("b2b_wr", 0, 1, 32'h200 + 32'(4 * i), model[i], 0, 1 + (i % 3), 32'h0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      access("b2b_rd", 1, 0, 32'h200 + 32'(4 * i), 0, 1, 0, 0, model[i]);
    end
  endtask

  initial begin
    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    address   = 32'd0;
    writeData = 32'd0;
    memRData  = 32'd0;
    memReady  = 1'b0;
    test_reset();
    test_read_miss_hit();
    test_write_then_read();
    test_alias();
    test_write_allocate();
    test_reset_mid_miss();
    test_rd_wr_priority();
    test_idle();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
